// File: rtl/pio_fifo.sv
// pio_fifo: TX/RX FIFO pair between the host bus and one PIO state machine.
// Define PIO_FIFO_JOIN_EN to add join_tx/join_rx depth-doubling inputs.
module pio_fifo #(
    parameter int DEPTH = 4,
    localparam int LW = $clog2(DEPTH) + 1,
`ifdef PIO_FIFO_JOIN_EN
    localparam int OW = LW + 1
`else
    localparam int OW = LW
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   tx_wdata,
    input  logic          tx_write,
    output logic          tx_full,
    output logic [OW-1:0] tx_level,
    output logic [31:0]   rx_rdata,
    input  logic          rx_read,
    output logic          rx_empty,
    output logic [OW-1:0] rx_level,
    output logic [31:0]   sm_dout,
    output logic          sm_empty,
    input  logic          sm_pull,
    input  logic [31:0]   sm_din,
    input  logic          sm_push,
    output logic          sm_full,
`ifdef PIO_FIFO_JOIN_EN
    input  logic          join_tx,
    input  logic          join_rx,
`endif
    output logic [3:0]    flags,
    input  logic [3:0]    flags_clr
);

    localparam int PW = LW + 1;
    localparam int D2 = 2 * DEPTH;
    typedef logic [PW-1:0] ptr_t;

    logic jt, jr, flush;
    ptr_t tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    ptr_t rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    ptr_t tx_mask, rx_mask, tx_cap, rx_cap, tx_lvl, rx_lvl;
    logic tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic tx_wen, tx_ren, rx_wen, rx_ren;
    logic [LW-1:0] tx_widx, tx_ridx, rx_widx, rx_ridx;
    logic [3:0] flags_q, flags_d;
    logic [31:0] mem_q [D2];

`ifdef PIO_FIFO_JOIN_EN
    logic jt_q, jt_d, jr_q, jr_d;

    always_comb begin
        jt_d = join_tx;
        jr_d = join_rx;
    end

    always_ff @(posedge clk) begin
        jt_q <= jt_d;
        jr_q <= jr_d;
    end

    // A mode change re-partitions the RAM, so queued words are dropped
    assign flush = (jt_d != jt_q) | (jr_d != jr_q);
    assign jt = jt_q;
    assign jr = jr_q & ~jt_q;
`else
    logic unused_ok;
    assign jt = 1'b0;
    assign jr = 1'b0;
    assign flush = 1'b0;
    assign unused_ok = ^{tx_lvl[PW-1], rx_lvl[PW-1]};
`endif

    // A disabled direction gets capacity 0: permanently full and empty
    always_comb begin
        tx_mask = jt ? ptr_t'(2 * D2 - 1) : ptr_t'(D2 - 1);
        rx_mask = jr ? ptr_t'(2 * D2 - 1) : ptr_t'(D2 - 1);
        tx_cap = jr ? '0 : (jt ? ptr_t'(D2) : ptr_t'(DEPTH));
        rx_cap = jt ? '0 : (jr ? ptr_t'(D2) : ptr_t'(DEPTH));
        tx_lvl = (tx_wp_q - tx_rp_q) & tx_mask;
        rx_lvl = (rx_wp_q - rx_rp_q) & rx_mask;
        tx_full_s = (tx_lvl == tx_cap);
        rx_full_s = (rx_lvl == rx_cap);
        tx_empty_s = (tx_lvl == '0);
        rx_empty_s = (rx_lvl == '0);
    end

    always_comb begin
        tx_widx = jt ? tx_wp_q[LW-1:0] : {1'b0, tx_wp_q[LW-2:0]};
        tx_ridx = jt ? tx_rp_q[LW-1:0] : {1'b0, tx_rp_q[LW-2:0]};
        rx_widx = jr ? rx_wp_q[LW-1:0] : {1'b1, rx_wp_q[LW-2:0]};
        rx_ridx = jr ? rx_rp_q[LW-1:0] : {1'b1, rx_rp_q[LW-2:0]};
    end

    always_comb begin
        tx_wen = tx_write & ~tx_full_s;
        tx_ren = sm_pull & ~tx_empty_s;
        rx_wen = sm_push & ~rx_full_s;
        rx_ren = rx_read & ~rx_empty_s;
        tx_wp_d = tx_wen ? (tx_wp_q + ptr_t'(1)) & tx_mask : tx_wp_q;
        tx_rp_d = tx_ren ? (tx_rp_q + ptr_t'(1)) & tx_mask : tx_rp_q;
        rx_wp_d = rx_wen ? (rx_wp_q + ptr_t'(1)) & rx_mask : rx_wp_q;
        rx_rp_d = rx_ren ? (rx_rp_q + ptr_t'(1)) & rx_mask : rx_rp_q;
        if (flush) begin
            tx_wp_d = '0;
            tx_rp_d = '0;
            rx_wp_d = '0;
            rx_rp_d = '0;
        end
        flags_d = (flags_q & ~flags_clr) | {rx_read & rx_empty_s,
                                            tx_write & tx_full_s,
                                            sm_push & rx_full_s,
                                            sm_pull & tx_empty_s};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
            flags_q <= '0;
        end else begin
            tx_wp_q <= tx_wp_d;
            tx_rp_q <= tx_rp_d;
            rx_wp_q <= rx_wp_d;
            rx_rp_q <= rx_rp_d;
            flags_q <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_wen) mem_q[tx_widx] <= tx_wdata;
        if (rx_wen) mem_q[rx_widx] <= sm_din;
    end

    assign tx_full = tx_full_s;
    assign sm_empty = tx_empty_s;
    assign sm_full = rx_full_s;
    assign rx_empty = rx_empty_s;
    assign tx_level = tx_lvl[OW-1:0];
    assign rx_level = rx_lvl[OW-1:0];
    assign sm_dout = tx_empty_s ? '0 : mem_q[tx_ridx];
    assign rx_rdata = rx_empty_s ? '0 : mem_q[rx_ridx];
    assign flags = flags_q;

endmodule

// File: doc/pio_fifo.md
# pio_fifo

Host-side FIFO pair for one PIO state machine, sitting between the CPU bus and the machine's FIFO port. The TX FIFO carries words written by the host to the machine, which consumes them with `pull` from a show-ahead head. The RX FIFO carries words the machine writes with `push` back to the host. The block also keeps sticky stall, overflow and underflow flags that the host can read and clear.

## Interface
- DEPTH, 4, entries per FIFO; power of two, ≥2
- LW, $clog2(DEPTH)+1, level width (derived)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- tx_wdata  in  32  host write data
- tx_write  in  1  host write strobe
- tx_full  out  1  TX full
- tx_level  out  LW  TX occupancy
- rx_rdata  out  32  RX head; 0 when RX empty
- rx_read  in  1  host read/pop strobe
- rx_empty  out  1  RX empty
- rx_level  out  LW  RX occupancy
- sm_dout  out  32  TX head to machine `din`; 0 when TX empty
- sm_empty  out  1  TX empty to machine
- sm_pull  in  1  machine pull (pops TX)
- sm_din  in  32  machine push data
- sm_push  in  1  machine push strobe
- sm_full  out  1  RX full to machine
- flags  out  4  sticky {rx_under, tx_over, rx_stall, tx_stall}
- flags_clr  in  4  write-1-to-clear, same bit order

## Operation
- Each FIFO: circular RAM, rptr/wptr of LW bits (MSB = wrap bit); full = pointers equal except MSB; empty = pointers equal.
- TX: `tx_write` & !tx_full → store at wptr, wptr+1. `tx_write` & tx_full → word dropped, tx_over set.
- TX: `sm_pull` & !sm_empty → rptr+1. `sm_pull` & sm_empty → no pop, tx_stall set.
- RX: `sm_push` & !sm_full → store, wptr+1. `sm_push` & sm_full → dropped, rx_stall set.
- RX: `rx_read` & !rx_empty → rptr+1. `rx_read` & rx_empty → no pop, rx_under set.
- Full/empty are judged on pre-edge state: a write to a full FIFO is rejected even if a pop occurs in the same cycle. A pop of an empty FIFO is ignored even if a write occurs in the same cycle; the write is accepted.
- Simultaneous valid write and pop: both occur, level unchanged.
- Pointer arithmetic wraps modulo 2·DEPTH. Level = wptr − rptr (LW bits, 0..DEPTH).
- Flags: set has priority over a same-cycle clear of the same bit.
- Heads are show-ahead: `sm_dout`/`rx_rdata` always present mem[rptr], forced to 0 when empty.

## Timing
- Reset: pointers 0, levels 0, tx_full=sm_full=0, sm_empty=rx_empty=1, flags=0, heads 0. RAM contents are not cleared.
- Reset mid-operation discards all queued words, with the next-cycle state equal to post-reset.
- Write to head latency: a word written into an empty FIFO at edge N appears on the head, with empty=0, after edge N (usable in cycle N+1).
- Pop: the head advances after the popping edge.
- Status outputs are registered or derived from registered pointers only. There is no combinational path from strobes to status.
- The machine-side strobes are single-cycle pulses. Each cycle a strobe is high counts as one operation.

## Configuration
- `PIO_FIFO_JOIN_EN` defined: adds inputs `join_tx` and `join_rx` (1 bit each).
  - `join_tx`=1: TX depth is 2·DEPTH using the RX storage. RX is disabled: sm_full=1, rx_empty=1, rx_level=0. LW grows by one bit internally, and tx_level is reported saturated at 2·DEPTH in LW+1 bits.
  - `join_rx`=1: mirror image.
  - Both set: join_tx wins.
  - Any change of a join input flushes both FIFOs on the next edge, as a reset of pointers only. Flags are kept.
- `PIO_FIFO_JOIN_EN` undefined: no join ports, fixed DEPTH each way.

## Test plan
- Reset, then write 0xA5A5_0001..0004 (DEPTH=4) → tx_full=1, tx_level=4. A 5th write sets flags[2] (tx_over) and the 5th word is lost. Four pulls return words 1..4 in order, then sm_empty=1.
- Pull while empty → flags[0]=1, sm_dout=0, no pointer change. Then flags_clr=4'b0001 → flags[0]=0.
- TX holding 2 words, `tx_write` and `sm_pull` in the same cycle → level stays 2 and the head advances to the 2nd word.
- RX full (4 pushes of 0x11..0x44), `rx_read` and `sm_push`(0x55) in the same cycle → push rejected, rx_stall set, rx_level=3, then reads return 0x22, 0x33, 0x44.
- Write 3 words, assert reset for 1 cycle mid-stream → tx_level=0, sm_empty=1, flags=0. 10 write/pull cycles then exercise pointer wrap, with data intact.
- With `PIO_FIFO_JOIN_EN` and join_tx=1: 8 writes accepted, 9th sets tx_over, sm_full=1. Toggling join_tx to 0 → both FIFOs empty.
